// File: rtl/serial_to_parallel_6bit.sv
// LSB-first serial-to-parallel receiver: start-marked frames of WIDTH bits into a registered word.
// Optional even-parity trailer bit when SERIAL_RX_PARITY_EN is defined.
module serial_to_parallel_6bit #(
  parameter int unsigned WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             serial_in,
  output logic [WIDTH-1:0] parallel_out,
  output logic             data_valid,
  output logic             busy,
  output logic             frame_err,
  output logic             parity_err
);

`ifdef SERIAL_RX_PARITY_EN
  localparam int unsigned NBITS = WIDTH + 1;
`else
  localparam int unsigned NBITS = WIDTH;
`endif
  localparam int unsigned   CNT_W = $clog2(WIDTH + 2);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NBITS - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] pout_q, pout_d;
  logic [WIDTH-1:0] word_c;
  logic             dv_q, dv_d;
  logic             busy_q, busy_d;
  logic             ferr_q, ferr_d;
  logic             perr_q, perr_d;

  // Shift register with the current serial bit dropped into position cnt_q (no-op on the parity bit).
  always_comb begin
    word_c = shift_q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (cnt_q == CNT_W'(i)) word_c[i] = serial_in;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    pout_d  = pout_q;
    busy_d  = busy_q;
    dv_d    = 1'b0;
    ferr_d  = 1'b0;
    perr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          cnt_d   = CNT_W'(1);
          shift_d = WIDTH'(serial_in);
          busy_d  = 1'b1;
        end
      end
      SHIFT: begin
        // An early start wins over everything, including the final-bit edge.
        if (start) begin
          ferr_d  = 1'b1;
          cnt_d   = CNT_W'(1);
          shift_d = WIDTH'(serial_in);
          busy_d  = 1'b1;
        end else if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          shift_d = word_c;
          pout_d  = word_c;
          dv_d    = 1'b1;
          busy_d  = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
          perr_d  = (^shift_q) ^ serial_in;
`endif
        end else if (cnt_q > LAST || cnt_q == '0) begin
          state_d = IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else begin
          shift_d = word_c;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      pout_q  <= '0;
      dv_q    <= 1'b0;
      busy_q  <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      pout_q  <= pout_d;
      dv_q    <= dv_d;
      busy_q  <= busy_d;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
    end
  end

  assign parallel_out = pout_q;
  assign data_valid   = dv_q;
  assign busy         = busy_q;
  assign frame_err    = ferr_q;
  assign parity_err   = perr_q;

endmodule

// File: tb/tb_serial_to_parallel_6bit.sv
// Scoreboard bench for serial_to_parallel_6bit: bit-list reference model, monitor checks on negedge.
module tb_serial_to_parallel_6bit;
  localparam int unsigned WIDTH = 6;
`ifdef SERIAL_RX_PARITY_EN
  localparam int unsigned N = WIDTH + 1;
  localparam bit PAR = 1'b1;
`else
  localparam int unsigned N = WIDTH;
  localparam bit PAR = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             serial_in = 1'b0;
  logic [WIDTH-1:0] parallel_out;
  logic             data_valid, busy, frame_err, parity_err;

  serial_to_parallel_6bit #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .serial_in(serial_in),
    .parallel_out(parallel_out), .data_valid(data_valid), .busy(busy),
    .frame_err(frame_err), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: bits collected since the last start, plus expected outputs for this cycle.
  bit               bits_q[$];
  logic [WIDTH:0]   sb_q[$];
  logic [WIDTH-1:0] exp_last = '0;
  bit               exp_dv = 0, exp_fe = 0, exp_pe = 0, exp_busy = 0;
  bit               mon_en = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  task automatic model_clear();
    bits_q.delete();
    exp_last = '0;
    exp_dv = 0; exp_fe = 0; exp_pe = 0; exp_busy = 0;
  endtask

  // Drive one bit, let the edge happen, then advance the model to the post-edge state.
  task automatic step(input bit s, input bit d);
    logic [WIDTH-1:0] w;
    int ones;
    start = s;
    serial_in = d;
    @(posedge clk);
    #1;
    exp_dv = 0; exp_fe = 0; exp_pe = 0;
    if (s) begin
      if (bits_q.size() > 0) exp_fe = 1;
      bits_q.delete();
      bits_q.push_back(d);
    end else if (bits_q.size() > 0) begin
      bits_q.push_back(d);
    end
    if (bits_q.size() == N) begin
      w = '0;
      ones = 0;
      for (int i = 0; i < int'(N); i++) begin
        if (i < int'(WIDTH)) w[i] = bits_q[i];
        ones += int'(bits_q[i]);
      end
      exp_last = w;
      exp_dv = 1;
      exp_pe = PAR ? bit'(ones % 2) : 1'b0;
      sb_q.push_back({exp_pe, w});
      bits_q.delete();
    end
    exp_busy = (bits_q.size() > 0);
  endtask

  task automatic send_frame(input logic [WIDTH-1:0] w, input bit par_flip);
    bit b;
    for (int i = 0; i < int'(N); i++) begin
      b = (i < int'(WIDTH)) ? w[i] : ((^w) ^ par_flip);
      step(i == 0, b);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, $urandom_range(1, 0) == 1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_pout"}, int'(parallel_out), 0);
    chk({tag, "_dv"}, int'(data_valid), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_ferr"}, int'(frame_err), 0);
    chk({tag, "_perr"}, int'(parity_err), 0);
  endtask

  // Monitor: per-cycle output flags against the model, word payloads popped from the scoreboard.
  always @(negedge clk) begin
    logic [WIDTH:0] e;
    if (mon_en) begin
      chk("data_valid", int'(data_valid), int'(exp_dv));
      chk("frame_err", int'(frame_err), int'(exp_fe));
      chk("busy", int'(busy), int'(exp_busy));
      chk("parity_err", int'(parity_err), int'(exp_pe));
      chk("parallel_out_hold", int'(parallel_out), int'(exp_last));
      if (data_valid) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_word", int'(parallel_out), -1);
        end else begin
          e = sb_q.pop_front();
          chk("word", int'(parallel_out), int'(e[WIDTH-1:0]));
          chk("word_parity", int'(parity_err), int'(e[WIDTH]));
        end
      end
    end
  end

  initial begin
    logic [WIDTH-1:0] w;
    // Reset state, then serial activity with no start
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_hold");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("reset_release");
    mon_en = 1;
    for (int i = 0; i < 20; i++) step(1'b0, i[0]);

    // Single frame, then back-to-back frames
    send_frame(6'b101101, 1'b0);
    idle(3);
    send_frame(6'b101101, 1'b0);
    send_frame(6'b110011, 1'b0);
    idle(2);

    // Aborted frame after 3 bits of all-ones
    step(1'b1, 1'b1); step(1'b0, 1'b1); step(1'b0, 1'b1);
    send_frame(6'b000110, 1'b0);
    idle(2);

    // Start on the final-bit edge aborts the frame
    for (int i = 0; i < int'(N) - 1; i++) step(i == 0, 1'b1);
    send_frame(6'b011010, 1'b0);
    idle(2);

    // Reset mid-frame after 4 bits, asserted asynchronously between edges
    step(1'b1, 1'b1); step(1'b0, 1'b0); step(1'b0, 1'b1); step(1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    check_all_zero("reset_mid");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);
    send_frame(6'b010101, 1'b0);
    idle(2);

    // Parity good then bad (in the default build the trailer flag is not sent)
    send_frame(6'b101101, 1'b0);
    send_frame(6'b101101, 1'b1);
    idle(2);

    // Random frames back-to-back and with gaps
    for (int k = 0; k < 40; k++) begin
      w = WIDTH'($urandom);
      send_frame(w, $urandom_range(3, 0) == 0);
      if ($urandom_range(1, 0) == 1) idle(int'($urandom_range(3, 0)));
    end

    // Random bit stream with sporadic starts, exercising aborts at every position
    for (int k = 0; k < 400; k++) step($urandom_range(6, 0) == 0, $urandom_range(1, 0) == 1);
    idle(int'(N) + 2);

    chk("scoreboard_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/serial_to_parallel_6bit.md
Name: serial_to_parallel_6bit

Overview:
- Receive-side counterpart of the team's 6-bit parallel-to-serial shifter.
- Samples an LSB-first serial bit stream, one bit per clock, starting at a one-cycle `start` frame marker.
- Assembles the bits into a WIDTH-bit word and presents it with a one-cycle `data_valid` strobe.
- Sits directly downstream of the serializer on the same clock, in the serial link path.

Parameters:
- WIDTH, 6, number of data bits per frame (legal values 2..16); all word-sized ports scale with it.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  frame marker; high in the cycle where bit 0 (LSB) is on serial_in.
- serial_in  input  1  serial data, LSB first, one bit per clock.
- parallel_out  output  WIDTH  last completed word; registered, held until the next completion.
- data_valid  output  1  one-cycle pulse: parallel_out was updated this cycle.
- busy  output  1  high while a frame is being received (after bit 0, until the last bit is sampled).
- frame_err  output  1  one-cycle pulse: a frame was aborted by an early start.
- parity_err  output  1  one-cycle pulse alongside data_valid when the parity check fails; constant 0 when the feature is compiled out.

Behaviour:
- Reset (rst_n=0, asynchronous): everything clears immediately and holds while low.
  - State = IDLE; bit counter = 0; shift register = 0.
  - parallel_out=0, data_valid=0, busy=0, frame_err=0, parity_err=0.
- FSM, two states:
  - IDLE: if start=1, sample serial_in into bit 0, set counter=1, go to SHIFT. Otherwise stay; serial_in is ignored.
  - SHIFT: each edge, sample serial_in into bit position `counter` and increment counter.
  - SHIFT, last bit: at the edge sampling the final bit (counter==N-1, where N=WIDTH, or WIDTH+1 with parity), go to IDLE and register the completed word into parallel_out. data_valid is high for exactly the following cycle.
- Timing and latency:
  - Edges E0..E(WIDTH-1) sample bits 0..WIDTH-1, with E0 being the edge at which start=1.
  - parallel_out and data_valid change at E(WIDTH-1).
  - Latency from start to data_valid is WIDTH cycles.
- busy: 1 from E0 until the final-bit edge, where it returns to 0.
- Back-to-back frames: start=1 at the very next edge after the final bit begins a new frame with no gap. Sustained throughput is one word per N cycles.
- start while in SHIFT:
  - The current partial frame is discarded and parallel_out is unchanged.
  - frame_err pulses for one cycle.
  - The sampled bit becomes bit 0 of a new frame, with counter=1.
- Counter width is $clog2(WIDTH+2). Counter values outside 0..N-1 are unreachable; if reached, return to IDLE.
- Reset in the middle of a frame: the partial frame is discarded and no data_valid is produced.
- Pulse outputs: data_valid, frame_err and parity_err are high for at most one cycle per event. Each is 0 in every other cycle.

Optional Feature:
- Macro: SERIAL_RX_PARITY_EN.
- When defined:
  - Each frame carries WIDTH data bits followed by one even-parity bit, so N=WIDTH+1.
  - Completion occurs on the parity-bit edge, giving a latency of WIDTH+1 cycles.
  - parity_err = XOR of (data bits, parity bit), pulsed together with data_valid.
  - The word is still delivered when parity fails.
- When undefined:
  - N=WIDTH and parity_err is tied to 0.
  - The port is still present so instantiations are identical in both builds.

Test Plan:
- Reset check: hold rst_n=0, then release. Required: every output is 0. Then drive serial_in toggling with no start for 20 cycles. Required: data_valid never asserts and busy=0.
- Single frame: start=1 with bits 1,0,1,1,0,1 on consecutive cycles. Required: parallel_out=6'b101101, a single data_valid pulse 6 cycles after start, busy high for the first 5 cycles.
- Back-to-back frames: 6'b101101 then 6'b110011, with start for the second frame immediately after the first frame's last bit. Required: two data_valid pulses 6 cycles apart, with the corresponding values in order.
- Aborted frame: start a frame with 6'b111111, then assert start again after 3 bits and send 6'b000110. Required: frame_err pulses once, then one data_valid with parallel_out=6'b000110. parallel_out must never show a 6'b111111 fragment.
- Reset mid-frame: drop rst_n after 4 bits of a frame. Required: all outputs clear at once and no data_valid follows. Then send 6'b010101. Required: it is received correctly.
- Parity build (SERIAL_RX_PARITY_EN): send 6'b101101 with parity bit 0, then the same word with parity bit 1. Required: parity_err=0 on the first word and 1 on the second, each aligned with data_valid, and data_valid 7 cycles after start.
